// File: rtl/ssd1331_spi_receiver.sv
// SSD1331 SPI responder: oversampled byte receiver, command decoder and pixel write port.
// Optional SSD1331_COLOR16_EN selects 65k-colour (two bytes per pixel), else 256-colour.
`timescale 1ns/1ps
module ssd1331_spi_receiver #(
    parameter int NUM_COL = 96,
    parameter int NUM_ROW = 64,
    parameter int CW = $clog2(NUM_COL),
    parameter int RW = $clog2(NUM_ROW),
`ifdef SSD1331_COLOR16_EN
    parameter int PW = 16
`else
    parameter int PW = 8
`endif
) (
    input  logic          i_CLK,
    input  logic          i_RST,
    input  logic          i_CS,
    input  logic          i_SCK,
    input  logic          i_MOSI,
    input  logic          i_DC,
    input  logic          i_RES,
    output logic          o_BYTE_VALID,
    output logic [7:0]    o_BYTE,
    output logic          o_BYTE_IS_DATA,
    output logic          o_PIX_WE,
    output logic [CW-1:0] o_PIX_COL,
    output logic [RW-1:0] o_PIX_ROW,
    output logic [PW-1:0] o_PIX_DATA,
    output logic          o_FRAME_DONE,
    output logic          o_DISPLAY_ON,
    output logic          o_CMD_ERR
);

    typedef enum logic {S_OPCODE, S_ARGS} state_t;

    logic [1:0] cs_sy, sck_sy, mosi_sy, dc_sy, res_sy;
    logic       cs_d, sck_d;
    logic       cs_s, sck_s, mosi_s, dc_s, clr;
    logic       bit_ok;

    assign cs_s   = cs_sy[1];
    assign sck_s  = sck_sy[1];
    assign mosi_s = mosi_sy[1];
    assign dc_s   = dc_sy[1];
    assign clr    = ~res_sy[1];
    // A CS rise landing with the final SCK rise still completes the byte
    assign bit_ok = sck_s & ~sck_d & (~cs_s | ~cs_d);

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            cs_sy   <= 2'b11;
            sck_sy  <= 2'b00;
            mosi_sy <= 2'b00;
            dc_sy   <= 2'b00;
            res_sy  <= 2'b11;
            cs_d    <= 1'b1;
            sck_d   <= 1'b0;
        end else begin
            cs_sy   <= {cs_sy[0], i_CS};
            sck_sy  <= {sck_sy[0], i_SCK};
            mosi_sy <= {mosi_sy[0], i_MOSI};
            dc_sy   <= {dc_sy[0], i_DC};
            res_sy  <= {res_sy[0], i_RES};
            cs_d    <= cs_s;
            sck_d   <= sck_s;
        end
    end

    logic [7:0] shreg;
    logic [2:0] bit_cnt;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            shreg <= '0; bit_cnt <= '0; o_BYTE_VALID <= 1'b0;
            o_BYTE <= '0; o_BYTE_IS_DATA <= 1'b0;
        end else if (clr) begin
            shreg <= '0; bit_cnt <= '0; o_BYTE_VALID <= 1'b0;
            o_BYTE <= '0; o_BYTE_IS_DATA <= 1'b0;
        end else begin
            o_BYTE_VALID <= 1'b0;
            if (bit_ok) begin
                shreg   <= {shreg[6:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    o_BYTE_VALID   <= 1'b1;
                    o_BYTE         <= {shreg[6:0], mosi_s};
                    o_BYTE_IS_DATA <= dc_s;
                end
            end else if (cs_s) begin
                bit_cnt <= '0;
            end
        end
    end

    // [4] flags an unknown opcode, [3:0] is the argument count
    function automatic logic [4:0] arg_info(input logic [7:0] b);
        case (b) inside
            8'h15, 8'h75: return 5'd2;
            8'h21:        return 5'd7;
            8'h22:        return 5'd10;
            8'h23:        return 5'd6;
            8'h25:        return 5'd4;
            8'h26, [8'h81:8'h83], 8'h87, [8'h8A:8'h8C], [8'hA0:8'hA2],
            8'hA8, 8'hAD, 8'hB0, 8'hB1, 8'hB3, 8'hBB, 8'hBE:
                          return 5'd1;
            8'h2E, 8'h2F, [8'hA4:8'hA7], 8'hAE, 8'hAF, 8'hE3:
                          return 5'd0;
            default:      return 5'h10;
        endcase
    endfunction

    function automatic logic [CW-1:0] clamp_col(input logic [7:0] b);
        return (b > 8'(NUM_COL - 1)) ? CW'(NUM_COL - 1) : b[CW-1:0];
    endfunction

    function automatic logic [RW-1:0] clamp_row(input logic [7:0] b);
        return (b > 8'(NUM_ROW - 1)) ? RW'(NUM_ROW - 1) : b[RW-1:0];
    endfunction

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] op, arg0, exec_op;
    logic       got0, exec, err, pix_byte;
    logic [4:0] info;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        exec     = 1'b0;
        err      = 1'b0;
        pix_byte = 1'b0;
        exec_op  = op;
        info     = arg_info(o_BYTE);
        if (o_BYTE_VALID) begin
            if (o_BYTE_IS_DATA) begin
                pix_byte = 1'b1;
                if (state == S_ARGS) begin
                    err     = 1'b1;
                    state_n = S_OPCODE;
                end
            end else if (state == S_OPCODE) begin
                exec_op = o_BYTE;
                cnt_n   = info[3:0];
                if (info[3:0] == 4'd0) begin
                    exec = ~info[4];
                    err  = info[4];
                end else begin
                    state_n = S_ARGS;
                end
            end else begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    exec    = 1'b1;
                    state_n = S_OPCODE;
                end
            end
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state <= S_OPCODE; cnt <= '0; op <= '0; arg0 <= '0; got0 <= 1'b0;
        end else if (clr) begin
            state <= S_OPCODE; cnt <= '0; op <= '0; arg0 <= '0; got0 <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (o_BYTE_VALID && !o_BYTE_IS_DATA) begin
                if (state == S_OPCODE) begin
                    op   <= o_BYTE;
                    got0 <= 1'b0;
                end else if (!got0) begin
                    arg0 <= o_BYTE;
                    got0 <= 1'b1;
                end
            end
        end
    end

    logic          pix_fire;
    logic [PW-1:0] pix_val;

`ifdef SSD1331_COLOR16_EN
    logic       hi_valid;
    logic [7:0] hi_byte;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            hi_valid <= 1'b0; hi_byte <= '0;
        end else if (clr) begin
            hi_valid <= 1'b0; hi_byte <= '0;
        end else if (o_BYTE_VALID) begin
            if (o_BYTE_IS_DATA && !hi_valid) begin
                hi_byte  <= o_BYTE;
                hi_valid <= 1'b1;
            end else begin
                hi_valid <= 1'b0;
            end
        end else if (cs_s && !cs_d) begin
            hi_valid <= 1'b0;
        end
    end

    assign pix_fire = pix_byte & hi_valid;
    assign pix_val  = {hi_byte, o_BYTE};
`else
    assign pix_fire = pix_byte;
    assign pix_val  = o_BYTE;
`endif

    logic [CW-1:0] col_start, col_end, col, c_lo, c_hi;
    logic [RW-1:0] row_start, row_end, row, r_lo, r_hi;

    always_comb begin
        c_lo = clamp_col(arg0);
        c_hi = clamp_col(o_BYTE);
        r_lo = clamp_row(arg0);
        r_hi = clamp_row(o_BYTE);
        if (c_hi < c_lo) c_hi = c_lo;
        if (r_hi < r_lo) r_hi = r_lo;
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            col_start <= '0; col_end <= CW'(NUM_COL - 1); col <= '0;
            row_start <= '0; row_end <= RW'(NUM_ROW - 1); row <= '0;
            o_PIX_WE <= 1'b0; o_PIX_COL <= '0; o_PIX_ROW <= '0; o_PIX_DATA <= '0;
            o_FRAME_DONE <= 1'b0; o_DISPLAY_ON <= 1'b0; o_CMD_ERR <= 1'b0;
        end else if (clr) begin
            col_start <= '0; col_end <= CW'(NUM_COL - 1); col <= '0;
            row_start <= '0; row_end <= RW'(NUM_ROW - 1); row <= '0;
            o_PIX_WE <= 1'b0; o_PIX_COL <= '0; o_PIX_ROW <= '0; o_PIX_DATA <= '0;
            o_FRAME_DONE <= 1'b0; o_DISPLAY_ON <= 1'b0; o_CMD_ERR <= 1'b0;
        end else begin
            o_PIX_WE     <= 1'b0;
            o_FRAME_DONE <= 1'b0;
            o_CMD_ERR    <= err;
            if (exec) begin
                if (exec_op == 8'h15) begin
                    col_start <= c_lo; col_end <= c_hi; col <= c_lo;
                end
                if (exec_op == 8'h75) begin
                    row_start <= r_lo; row_end <= r_hi; row <= r_lo;
                end
                if (exec_op == 8'hAF) o_DISPLAY_ON <= 1'b1;
                if (exec_op == 8'hAE) o_DISPLAY_ON <= 1'b0;
            end
            if (pix_fire) begin
                o_PIX_WE   <= 1'b1;
                o_PIX_COL  <= col;
                o_PIX_ROW  <= row;
                o_PIX_DATA <= pix_val;
                if (col == col_end) begin
                    col <= col_start;
                    if (row == row_end) begin
                        row          <= row_start;
                        o_FRAME_DONE <= 1'b1;
                    end else begin
                        row <= row + RW'(1);
                    end
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ssd1331_spi_receiver.sv
// Bench for ssd1331_spi_receiver (256-colour build): vector table, corner sequences, random stream.
`timescale 1ns/1ps
module tb_ssd1331_spi_receiver;

    localparam int NC = 96;
    localparam int NR = 64;

    logic clk = 1'b0, rst = 1'b1, cs = 1'b1, sck = 1'b0;
    logic mosi = 1'b0, dc = 1'b0, res = 1'b1;
    logic bv, is_data, we, fd, disp, err;
    logic [7:0] byte_o, pdata;
    logic [6:0] pcol;
    logic [5:0] prow;

    ssd1331_spi_receiver #(.NUM_COL(NC), .NUM_ROW(NR)) dut (
        .i_CLK(clk), .i_RST(rst), .i_CS(cs), .i_SCK(sck), .i_MOSI(mosi),
        .i_DC(dc), .i_RES(res), .o_BYTE_VALID(bv), .o_BYTE(byte_o),
        .o_BYTE_IS_DATA(is_data), .o_PIX_WE(we), .o_PIX_COL(pcol),
        .o_PIX_ROW(prow), .o_PIX_DATA(pdata), .o_FRAME_DONE(fd),
        .o_DISPLAY_ON(disp), .o_CMD_ERR(err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int  col;
        int  row;
        int  data;
        bit  fd;
    } pix_t;

    pix_t got_q[$];
    int   bv_cnt = 0;
    int   err_cnt = 0;

    always @(negedge clk) begin
        if (bv) bv_cnt++;
        if (err) err_cnt++;
        if (we) got_q.push_back('{int'(pcol), int'(prow), int'(pdata), fd});
    end

    int unsigned last_rise;

    task automatic send_bits(input logic [7:0] b, input int n, input logic d);
        cs = 1'b0;
        dc = d;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            #20 sck = 1'b1;
            last_rise = cyc;
            #20 sck = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d);
        send_bits(b, 8, d);
    endtask

    task automatic wait_bv(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bv) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0; dc = 1'b0; res = 1'b1;
        #30 rst = 1'b0;
        #30;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_bv"}, bv, 0);
        chk({tag, "_byte"}, byte_o, 0);
        chk({tag, "_isdata"}, is_data, 0);
        chk({tag, "_we"}, we, 0);
        chk({tag, "_col"}, pcol, 0);
        chk({tag, "_row"}, prow, 0);
        chk({tag, "_data"}, pdata, 0);
        chk({tag, "_fd"}, fd, 0);
        chk({tag, "_disp"}, disp, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Reference model: window walk expressed as a linear index over the window
    int   argc_t[256];
    int   ones[$]  = '{'h26, 'h81, 'h82, 'h83, 'h87, 'h8A, 'h8B, 'h8C, 'hA0,
                       'hA1, 'hA2, 'hA8, 'hAD, 'hB0, 'hB1, 'hB3, 'hBB, 'hBE};
    int   zeros[$] = '{'h2E, 'h2F, 'hA4, 'hA5, 'hA6, 'hA7, 'hAE, 'hAF, 'hE3};
    int   pend, mop, a0, nargs, ncs, nce, nrs, nre, co, ro, mdisp, merr;
    pix_t exp_q[$];

    task automatic model_init();
        foreach (argc_t[i]) argc_t[i] = -1;
        argc_t['h15] = 2; argc_t['h75] = 2; argc_t['h21] = 7;
        argc_t['h22] = 10; argc_t['h23] = 6; argc_t['h25] = 4;
        foreach (ones[i]) argc_t[ones[i]] = 1;
        foreach (zeros[i]) argc_t[zeros[i]] = 0;
        pend = 0; mop = 0; a0 = 0; nargs = 0;
        ncs = 0; nce = NC - 1; nrs = 0; nre = NR - 1;
        co = 0; ro = 0; mdisp = 0; merr = 0;
        exp_q.delete();
    endtask

    function automatic int clampv(input int v, input int n);
        return (v > n - 1) ? n - 1 : v;
    endfunction

    task automatic model_exec(input int op, input int x, input int y);
        int s, e;
        if (op == 'h15 || op == 'h75) begin
            s = clampv(x, op == 'h15 ? NC : NR);
            e = clampv(y, op == 'h15 ? NC : NR);
            if (e < s) e = s;
            if (op == 'h15) begin ncs = s; nce = e; co = 0; end
            else begin nrs = s; nre = e; ro = 0; end
        end
        if (op == 'hAF) mdisp = 1;
        if (op == 'hAE) mdisp = 0;
    endtask

    task automatic model_byte(input int b, input bit d);
        int w, h, k;
        if (!d) begin
            if (pend == 0) begin
                mop = b;
                nargs = 0;
                if (argc_t[b] < 0) merr++;
                else if (argc_t[b] == 0) model_exec(b, 0, 0);
                else pend = argc_t[b];
            end else begin
                if (nargs == 0) a0 = b;
                nargs++;
                pend--;
                if (pend == 0) model_exec(mop, a0, b);
            end
        end else begin
            if (pend > 0) begin
                merr++;
                pend = 0;
            end
            w = nce - ncs + 1;
            h = nre - nrs + 1;
            k = ro * w + co;
            exp_q.push_back('{ncs + co, nrs + ro, b, k == w * h - 1});
            k = (k + 1) % (w * h);
            co = k % w;
            ro = k / w;
        end
    endtask

    task automatic emit(input int b, input bit d);
        send_byte(8'(b), d);
        model_byte(b, d);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       d;
        logic       we;
        int         col;
        int         row;
        logic [7:0] data;
        logic       fd;
        logic       err;
        logic       disp;
    } vec_t;

    vec_t tbl[16];

    initial begin
        bit ok;
        int snap, esnap, n, r, x;
        logic [7:0] b;

        tbl = '{
            '{8'hAF, 1'b0, 1'b0,  0, 0, 8'h00, 1'b0, 1'b0, 1'b1},
            '{8'h15, 1'b0, 1'b0,  0, 0, 8'h00, 1'b0, 1'b0, 1'b1},
            '{8'h02, 1'b0, 1'b0,  0, 0, 8'h00, 1'b0, 1'b0, 1'b1},
            '{8'h03, 1'b0, 1'b0,  0, 0, 8'h00, 1'b0, 1'b0, 1'b1},
            '{8'h75, 1'b0, 1'b0,  0, 0, 8'h00, 1'b0, 1'b0, 1'b1},
            '{8'h01, 1'b0, 1'b0,  0, 0, 8'h00, 1'b0, 1'b0, 1'b1},
            '{8'h02, 1'b0, 1'b0,  0, 0, 8'h00, 1'b0, 1'b0, 1'b1},
            '{8'h11, 1'b1, 1'b1,  2, 1, 8'h11, 1'b0, 1'b0, 1'b1},
            '{8'h22, 1'b1, 1'b1,  3, 1, 8'h22, 1'b0, 1'b0, 1'b1},
            '{8'h33, 1'b1, 1'b1,  2, 2, 8'h33, 1'b0, 1'b0, 1'b1},
            '{8'h44, 1'b1, 1'b1,  3, 2, 8'h44, 1'b1, 1'b0, 1'b1},
            '{8'h15, 1'b0, 1'b0,  0, 0, 8'h00, 1'b0, 1'b0, 1'b1},
            '{8'hFF, 1'b0, 1'b0,  0, 0, 8'h00, 1'b0, 1'b0, 1'b1},
            '{8'h10, 1'b0, 1'b0,  0, 0, 8'h00, 1'b0, 1'b0, 1'b1},
            '{8'h5C, 1'b1, 1'b1, 95, 1, 8'h5C, 1'b0, 1'b0, 1'b1},
            '{8'h5D, 1'b1, 1'b1, 95, 2, 8'h5D, 1'b1, 1'b0, 1'b1}
        };

        #2;
        do_reset();
        check_zero("reset");

        foreach (tbl[i]) begin
            send_byte(tbl[i].b, tbl[i].d);
            wait_bv(ok);
            chk($sformatf("v%0d_bv_seen", i), ok, 1);
            if (ok) begin
                chk($sformatf("v%0d_byte", i), byte_o, tbl[i].b);
                chk($sformatf("v%0d_isdata", i), is_data, tbl[i].d);
                chk($sformatf("v%0d_latency", i), cyc - last_rise, 3);
                @(negedge clk);
                chk($sformatf("v%0d_we", i), we, tbl[i].we);
                if (tbl[i].we) begin
                    chk($sformatf("v%0d_col", i), pcol, tbl[i].col);
                    chk($sformatf("v%0d_row", i), prow, tbl[i].row);
                    chk($sformatf("v%0d_data", i), pdata, tbl[i].data);
                end
                chk($sformatf("v%0d_fd", i), fd, tbl[i].fd);
                chk($sformatf("v%0d_err", i), err, tbl[i].err);
                chk($sformatf("v%0d_disp", i), disp, tbl[i].disp);
            end
        end

        // partial byte discarded by CS, then 0xAE
        snap = bv_cnt;
        send_bits(8'hFF, 5, 1'b0);
        #20 cs = 1'b1;
        #60;
        chk("partial_no_bv", bv_cnt - snap, 0);
        send_byte(8'hAE, 1'b0);
        wait_bv(ok);
        chk("ae_bv_seen", ok, 1);
        chk("ae_byte", byte_o, 8'hAE);
        @(negedge clk);
        chk("ae_bv_count", bv_cnt - snap, 1);
        chk("ae_disp", disp, 0);

        // CS rises together with the last SCK rise
        b = 8'hAF;
        cs = 1'b0; dc = 1'b0;
        for (int i = 0; i < 7; i++) begin
            mosi = b[7-i];
            #20 sck = 1'b1;
            last_rise = cyc;
            #20 sck = 1'b0;
        end
        mosi = b[0];
        #20 sck = 1'b1; cs = 1'b1;
        last_rise = cyc;
        #20 sck = 1'b0;
        wait_bv(ok);
        chk("csedge_bv_seen", ok, 1);
        chk("csedge_byte", byte_o, 8'hAF);
        chk("csedge_latency", cyc - last_rise, 3);
        @(negedge clk);
        chk("csedge_disp", disp, 1);

        // panel reset pin
        res = 1'b0;
        #60;
        chk("res_disp", disp, 0);
        chk("res_byte", byte_o, 0);
        res = 1'b1;
        #40;

        // argument list aborted by a data byte
        do_reset();
        esnap = err_cnt;
        send_byte(8'h15, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'hAB, 1'b1);
        wait_bv(ok);
        chk("abort_bv_seen", ok, 1);
        @(negedge clk);
        chk("abort_err", err, 1);
        chk("abort_we", we, 1);
        chk("abort_col", pcol, 0);
        chk("abort_row", prow, 0);
        chk("abort_data", pdata, 8'hAB);
        send_byte(8'hAF, 1'b0);
        wait_bv(ok);
        @(negedge clk);
        chk("abort_next_err", err, 0);
        chk("abort_next_disp", disp, 1);
        chk("abort_err_count", err_cnt - esnap, 1);

        // async reset in the middle of a 0x22 argument list
        send_byte(8'h22, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_bits(8'h0F, 4, 1'b0);
        rst = 1'b1;
        #20;
        check_zero("rstmid");
        #10 rst = 1'b0;
        #30;
        send_byte(8'h15, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h5A, 1'b1);
        wait_bv(ok);
        chk("rstmid_bv_seen", ok, 1);
        @(negedge clk);
        chk("rstmid_we", we, 1);
        chk("rstmid_col", pcol, 1);
        chk("rstmid_row", prow, 0);
        chk("rstmid_err", err, 0);

        // random back-to-back stream against the model
        do_reset();
        model_init();
        got_q.delete();
        esnap = err_cnt;
        for (int op = 0; op < 80; op++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1: begin
                    emit(r == 0 ? 'h15 : 'h75, 0);
                    x = $urandom_range(0, 99);
                    emit(x, 0);
                    if ($urandom_range(0, 3) == 0) emit($urandom_range(0, 255), 0);
                    else emit(x + $urandom_range(0, 3), 0);
                end
                2: emit($urandom_range(0, 1) ? 'hAF : 'hAE, 0);
                3: begin emit('h81, 0); emit($urandom_range(0, 255), 0); end
                4: begin
                    emit('h21, 0);
                    repeat (7) emit($urandom_range(0, 255), 0);
                end
                5: begin
                    x = $urandom_range(0, 4);
                    emit(x == 0 ? 'h00 : x == 1 ? 'h10 : x == 2 ? 'h30 : x == 3 ? 'hFF : 'h90, 0);
                end
                6: begin
                    emit('h22, 0);
                    n = $urandom_range(0, 9);
                    repeat (n) emit($urandom_range(0, 255), 0);
                    emit($urandom_range(0, 255), 1);
                end
                default: begin
                    n = $urandom_range(1, 6);
                    repeat (n) emit($urandom_range(0, 255), 1);
                end
            endcase
        end
        #200;
        chk("rand_npix", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("rand%0d_col", i), got_q[i].col, exp_q[i].col);
            chk($sformatf("rand%0d_row", i), got_q[i].row, exp_q[i].row);
            chk($sformatf("rand%0d_data", i), got_q[i].data, exp_q[i].data);
            chk($sformatf("rand%0d_fd", i), got_q[i].fd, exp_q[i].fd);
        end
        chk("rand_err_count", err_cnt - esnap, merr);
        chk("rand_disp", disp, mdisp);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
